mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the execute stage, beside the ALU.
- Implements MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers.
- Runs a radix-2 shift-add multiply or restoring divide, one bit per cycle, so it never lengthens the ALU's combinational path.
- Drives a busy signal that the hazard logic uses to stall MFHI/MFLO and any new mult/div.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, coincident with the cycle HI/LO first show the new result.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset, when reset=1 at an edge:
  - state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter=0.
  - Applies mid-operation too: the in-flight operation is abandoned and HI/LO are not written.
- States: IDLE, RUN, FIX. busy = (state != IDLE), decoded from registered state.
- IDLE with start=1 at edge T0:
  - Latch the magnitudes of a and b (absolute values for signed ops).
  - Latch the result sign flags and op.
  - Clear the accumulator and set counter=0; go to RUN.
- RUN: one iteration per edge for WIDTH edges (T0+1 … T0+WIDTH), then go to FIX.
  - Multiply: conditional add of the multiplicand into the 2·WIDTH accumulator, then shift right.
  - Divide: shift the remainder left, trial subtract, set the quotient bit.
- FIX, at edge T0+WIDTH+1:
  - Apply sign correction; write hi/lo; done=1 for that cycle; return to IDLE.
  - busy is high for exactly WIDTH+1 cycles (33 for WIDTH=32), following edges T0 … T0+WIDTH.
- Arithmetic rules:
  - Signed multiply: the full 2·WIDTH two's-complement product, split as {hi, lo}.
  - Signed divide truncates toward zero. Remainder takes the sign of the dividend.
  - Signed overflow, a=-2^(WIDTH-1) and b=-1: lo=0x80000000, hi=0. No trap.
  - Divide by zero (b=0), signed or unsigned: lo=all ones, hi=a. The unit still takes the full latency. No trap.
- Handshake and conflicts:
  - start while busy=1 is ignored. The caller must hold the instruction in decode until busy=0.
  - start and done in the same cycle: the new start is accepted, since state is IDLE that cycle.
  - hi_we/lo_we in IDLE write wdata at the edge; hi and lo update on the next cycle.
  - hi_we/lo_we while busy=1 are ignored.
  - start=1 together with hi_we or lo_we in IDLE: start wins and the write is dropped.
  - hi_we and lo_we together: both registers take wdata.
- Operand inputs a, b and op are sampled only at the accepting edge. Later changes have no effect.
- hi and lo hold their value at all times other than the FIX write and MTHI/MTLO writes.

Test Plan:
- MULT with a=12, b=-34 (0xFFFFFFDE):
  - busy=1 for 33 cycles, then done pulses once.
  - lo=0xFFFFFE68 (-408), hi=0xFFFFFFFF.
- MULTU with a=b=0xFFFFFFFF:
  - hi=0xFFFFFFFE, lo=0x00000001.
  - The same operands under MULT give hi=0, lo=1.
- DIV, three cases:
  - a=-7, b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - a=7, b=-2: lo=-3, hi=1.
  - a=0x80000000, b=-1: lo=0x80000000, hi=0.
- DIVU, two cases:
  - a=100, b=7: lo=14, hi=2.
  - a=1234, b=0: lo=0xFFFFFFFF, hi=1234, after the full latency.
- Handshake:
  - A second start with different operands, pulsed mid-operation, is ignored, and the first result is intact.
  - MTLO wdata=0x55 while busy is dropped. The same MTLO in IDLE gives lo=0x55 the next cycle.
  - start asserted in the done cycle is accepted.
- Reset:
  - Assert reset at cycle 10 of a DIV: next cycle busy=0, done=0, hi=lo=0.
  - No done pulse follows.
  - A new MULT 3×5 then completes with lo=15.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit that owns the HI/LO registers.
// A result takes WIDTH+2 edges from acceptance to the done pulse; busy stalls dependent instructions.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_op_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_sa;
    logic               w_sb;
    logic               w_dvz;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Operand magnitudes and sign flags; divide-by-zero bypasses sign handling so HI returns a unchanged
    always_comb begin
        w_sa  = a[WIDTH-1] & ~op[0];
        w_sb  = b[WIDTH-1] & ~op[0];
        w_dvz = op[1] & (b == {WIDTH{1'b0}});
        if (w_sa && !w_dvz) begin
            w_mag_a = {WIDTH{1'b0}} - a;
        end else begin
            w_mag_a = a;
        end
        if (w_sb) begin
            w_mag_b = {WIDTH{1'b0}} - b;
        end else begin
            w_mag_b = b;
        end
    end

    // One iteration: shift-add multiply step, or shift / trial-subtract divide step
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                  + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_opnd};
        if (r_op_div) begin
            if (!w_trial[WIDTH]) begin
                w_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Sign correction of the finished magnitude result
    always_comb begin
        w_prod = r_neg_q ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
        w_quo  = r_neg_q ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
        w_rem  = r_neg_r ? ({WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
        if (r_op_div) begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_op_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opnd   <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_cnt    <= {CW{1'b0}};
                        r_op_div <= op[1];
                        r_neg_q  <= (w_sa ^ w_sb) & ~w_dvz;
                        r_neg_r  <= w_sa & op[1] & ~w_dvz;
                        // Divide keeps the dividend in the low half; multiply keeps the multiplier there
                        r_opnd   <= op[1] ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                    end else begin
                        if (hi_we) begin
                            r_hi <= wdata;
                        end
                        if (lo_we) begin
                            r_lo <= wdata;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: architectural HI/LO after an operation, from plain arithmetic
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] p;
        int          sx;
        int          sy;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                sp = longint'(sx) * longint'(sy);
                p = sp;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b10: begin
                if (y == 32'd0) begin
                    m_hi = x;
                    m_lo = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_hi = 32'd0;
                    m_lo = 32'h8000_0000;
                end else begin
                    m_lo = sx / sy;
                    m_hi = sx % sy;
                end
            end
            default: begin
                if (y == 32'd0) begin
                    m_hi = x;
                    m_lo = 32'hFFFF_FFFF;
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
        endcase
    endfunction

    // Present a start for one edge, then scramble operands to show they are not re-sampled
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
        ref_op(o, x, y);
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int nb;
        int g;
        nb = 0;
        g = 0;
        while (done !== 1'b1 && g < 60) begin
            if (busy === 1'b1) nb++;
            tick();
            g++;
        end
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        int npulse;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Directed arithmetic cases
        issue(2'b00, 32'd12, 32'hFFFF_FFDE);
        wait_done("mult_12_m34", 33);
        chk("mult_12_m34_lo_const", lo, 32'hFFFF_FE68);
        chk("mult_12_m34_hi_const", hi, 32'hFFFF_FFFF);
        tick();
        chk("done_single_pulse", {31'd0, done}, 32'd0);
        chk("hold_lo", lo, 32'hFFFF_FE68);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 33);
        chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mult_m1_m1", 33);
        chk("mult_m1_m1_lo_const", lo, 32'd1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", 33);
        chk("div_m7_2_lo_const", lo, 32'hFFFF_FFFD);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_7_m2", 33);
        chk("div_7_m2_hi_const", hi, 32'd1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 33);
        chk("div_ovf_lo_const", lo, 32'h8000_0000);
        issue(2'b11, 32'd100, 32'd7);
        wait_done("divu_100_7", 33);
        chk("divu_100_7_lo_const", lo, 32'd14);
        issue(2'b11, 32'd1234, 32'd0);
        wait_done("divu_by0", 33);
        chk("divu_by0_hi_const", hi, 32'd1234);
        issue(2'b10, 32'hFFFF_FF00, 32'd0);
        wait_done("div_by0_neg", 33);

        // Randomized operations with biased divisors
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb);
            wait_done($sformatf("rand%0d_op%0d", i, ro), 33);
        end

        // Start and MTLO/MTHI while busy are ignored
        issue(2'b01, 32'h0000_1234, 32'h0000_5678);
        tick();
        tick();
        tick();
        op = 2'b10; a = 32'd99; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wdata = 32'h55; lo_we = 1'b1;
        tick();
        lo_we = 1'b0; hi_we = 1'b1;
        tick();
        hi_we = 1'b0;
        wait_done("ignore_busy", 27);
        tick();

        // MTLO in IDLE, then both writes together
        wdata = 32'h55; lo_we = 1'b1;
        tick();
        lo_we = 1'b0;
        m_lo = 32'h55;
        chk("mtlo_idle", lo, m_lo);
        chk("mtlo_hi_untouched", hi, m_hi);
        wdata = 32'hA5A5_0F0F; hi_we = 1'b1; lo_we = 1'b1;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        m_hi = 32'hA5A5_0F0F;
        m_lo = 32'hA5A5_0F0F;
        chk("mthilo_hi", hi, m_hi);
        chk("mthilo_lo", lo, m_lo);

        // Start beats a simultaneous MTHI
        wdata = 32'hDEAD_BEEF; hi_we = 1'b1;
        issue(2'b11, 32'd100, 32'd7);
        hi_we = 1'b0;
        wait_done("start_wins", 33);

        // Start in the done cycle is accepted
        issue(2'b00, 32'd3, 32'hFFFF_FFFB);
        chk("start_in_done_busy", {31'd0, busy}, 32'd1);
        wait_done("start_in_done", 33);

        // Reset mid-divide abandons the operation
        issue(2'b10, 32'd1000, 32'd7);
        for (int k = 0; k < 9; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, m_hi);
        chk("midrst_lo", lo, m_lo);
        npulse = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) npulse++;
            tick();
        end
        chk("midrst_no_done", 32'(npulse), 32'd0);
        chk("midrst_lo_held", lo, m_lo);
        issue(2'b00, 32'd3, 32'd5);
        wait_done("mult_3_5", 33);
        chk("mult_3_5_lo_const", lo, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
